// File: rtl/vga_grid_capture_pkg.sv
// Shared constants and types for the VGA grid capture block: 480p timing,
// game-grid geometry, the colour word and the capture state encoding.
package vga_grid_capture_pkg;

   // 640x480 @ 60 Hz line and frame timing
   localparam int VGA_H_TOTAL     = 800;
   localparam int VGA_H_SYNC      = 96;
   localparam int VGA_H_BP        = 48;
   localparam int VGA_H_ACT_START = VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL     = 525;
   localparam int VGA_V_SYNC      = 2;
   localparam int VGA_V_BP        = 33;
   localparam int VGA_V_ACT_START = VGA_V_SYNC + VGA_V_BP;

   // Game grid: 8x8 cells of 2**CELL_LOG2 pixels, top-left corner in active space
   localparam int VGA_GRID_X0   = 192;
   localparam int VGA_GRID_Y0   = 112;
   localparam int VGA_CELL_LOG2 = 5;
   localparam int GRID_DIM      = 8;

   // Position counters and measurements are 10 bits wide
   localparam int CNT_W = 10;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   typedef logic [1:0] cap_state_t;

   localparam cap_state_t ST_IDLE  = 2'd0;
   localparam cap_state_t ST_ARMED = 2'd1;
   localparam cap_state_t ST_CAP   = 2'd2;

endpackage

// File: rtl/vga_grid_capture_if.sv
// VGA video stream: active-low syncs plus 12-bit colour, one pixel per clock.
interface vga_grid_capture_if;
   logic       hsync;
   logic       vsync;
   logic [3:0] r;
   logic [3:0] g;
   logic [3:0] b;

   modport master (output hsync, vsync, r, g, b);
   modport slave  (input  hsync, vsync, r, g, b);
endinterface

// File: rtl/vga_grid_capture_timing_meter.sv
// Input registers, sync edge detection, pixel/line position counters and
// line/frame period measurement with lock qualification.
module vga_timing_meter
   import vga_grid_capture_pkg::*;
#(
   parameter int H_TOTAL = VGA_H_TOTAL,
   parameter int V_TOTAL = VGA_V_TOTAL
)
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_hsync,
   input  logic             i_vsync,
   input  rgb12_t           i_rgb,
   output rgb12_t           o_rgb,
   output logic             o_vs_fall,
   output logic [CNT_W-1:0] o_hcnt,
   output logic [CNT_W-1:0] o_vcnt,
   output logic [CNT_W-1:0] o_line_len,
   output logic [CNT_W-1:0] o_frame_lines,
   output logic             o_locked
);

   localparam logic [CNT_W-1:0] H_TOT_C = CNT_W'(H_TOTAL);
   localparam logic [CNT_W-1:0] V_TOT_C = CNT_W'(V_TOTAL);

   logic             hs_p0, hs_p1;
   logic             vs_p0, vs_p1;
   rgb12_t           rgb_p0;
   logic             hs_fall, vs_fall;
   logic [CNT_W-1:0] hcnt, vcnt;
   logic             line_ok_p0, line_ok_p1, frame_ok;

   // Counters and measurements stick at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Register the incoming stream once; the second sync stage is edge history
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hs_p0  <= 1'b0;
         hs_p1  <= 1'b0;
         vs_p0  <= 1'b0;
         vs_p1  <= 1'b0;
         rgb_p0 <= '0;
      end else begin
         hs_p0  <= i_hsync;
         hs_p1  <= hs_p0;
         vs_p0  <= i_vsync;
         vs_p1  <= vs_p0;
         rgb_p0 <= i_rgb;
      end
   end

   assign hs_fall = hs_p1 & ~hs_p0;
   assign vs_fall = vs_p1 & ~vs_p0;

   // Pixel and line position, restarted by the sync falling edges
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hcnt <= '0;
         vcnt <= '0;
      end else begin
         hcnt <= hs_fall ? '0 : sat_inc(hcnt);
         if (vs_fall)
            vcnt <= '0;
         else if (hs_fall)
            vcnt <= sat_inc(vcnt);
      end
   end

   // Period measurement; lock needs two good lines and one good frame
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_line_len    <= '0;
         o_frame_lines <= '0;
         line_ok_p0    <= 1'b0;
         line_ok_p1    <= 1'b0;
         frame_ok      <= 1'b0;
      end else begin
         if (hs_fall) begin
            o_line_len <= sat_inc(hcnt);
            line_ok_p0 <= (sat_inc(hcnt) == H_TOT_C);
            line_ok_p1 <= line_ok_p0;
         end
         if (vs_fall) begin
            o_frame_lines <= sat_inc(vcnt);
            frame_ok      <= (sat_inc(vcnt) == V_TOT_C);
         end
      end
   end

   assign o_locked  = line_ok_p0 & line_ok_p1 & frame_ok;
   assign o_vs_fall = vs_fall;
   assign o_hcnt    = hcnt;
   assign o_vcnt    = vcnt;
   assign o_rgb     = rgb_p0;

endmodule

// File: rtl/vga_grid_capture.sv
// Receive side of the VGA output: measures timing and, on request, samples
// the centre pixel of each 8x8 grid cell of one full frame into a buffer.
module vga_grid_capture
   import vga_grid_capture_pkg::*;
#(
   parameter int H_TOTAL     = VGA_H_TOTAL,
   parameter int V_TOTAL     = VGA_V_TOTAL,
   parameter int H_ACT_START = VGA_H_ACT_START,
   parameter int V_ACT_START = VGA_V_ACT_START,
   parameter int GRID_X0     = VGA_GRID_X0,
   parameter int GRID_Y0     = VGA_GRID_Y0,
   parameter int CELL_LOG2   = VGA_CELL_LOG2
)
(
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   vga_grid_capture_if.slave        vid,
   input  logic                     i_capture,
   input  logic [5:0]               i_rd_addr,
   output logic [11:0]              o_rd_data,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_valid,
   output logic                     o_locked,
   output logic                     o_err,
   output logic [CNT_W-1:0]         o_line_len,
   output logic [CNT_W-1:0]         o_frame_lines
);

   localparam int CELL   = 1 << CELL_LOG2;
   localparam int GRID_W = GRID_DIM * CELL;

   // Grid origin expressed in counter space, plus in-cell centre offset
   localparam logic signed [11:0] X_BASE   = 12'(H_ACT_START + GRID_X0);
   localparam logic signed [11:0] Y_BASE   = 12'(V_ACT_START + GRID_Y0);
   localparam logic signed [11:0] GRID_W_S = 12'(GRID_W);
   localparam logic        [11:0] CELL_MSK = 12'(CELL - 1);
   localparam logic        [11:0] CELL_MID = 12'(CELL / 2);

   rgb12_t           rgb;
   logic             vs_fall;
   logic [CNT_W-1:0] hcnt, vcnt;
   logic             locked;

   logic signed [11:0] gx, gy;
   logic               hit_x, hit_y;
   logic [2:0]         col, row;
   logic [5:0]         cell_addr;
   logic               cell_we;

   cap_state_t state;
   logic [5:0] wr_cnt;
   logic [11:0] cell_mem [64];

   vga_timing_meter #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL)
   ) u_meter (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_hsync       (vid.hsync),
      .i_vsync       (vid.vsync),
      .i_rgb         ({vid.r, vid.g, vid.b}),
      .o_rgb         (rgb),
      .o_vs_fall     (vs_fall),
      .o_hcnt        (hcnt),
      .o_vcnt        (vcnt),
      .o_line_len    (o_line_len),
      .o_frame_lines (o_frame_lines),
      .o_locked      (locked)
   );

   // Position relative to the grid corner; negative means left of / above it
   assign gx = $signed({2'b00, hcnt}) - X_BASE;
   assign gy = $signed({2'b00, vcnt}) - Y_BASE;

   assign hit_x = (gx >= 12'sd0) && (gx < GRID_W_S) && (($unsigned(gx) & CELL_MSK) == CELL_MID);
   assign hit_y = (gy >= 12'sd0) && (gy < GRID_W_S) && (($unsigned(gy) & CELL_MSK) == CELL_MID);

   assign col       = 3'($unsigned(gx) >> CELL_LOG2);
   assign row       = 3'($unsigned(gy) >> CELL_LOG2);
   assign cell_addr = {row, col};
   assign cell_we   = (state == ST_CAP) && locked && hit_x && hit_y;

   // Capture control: arm, wait for a locked frame start, collect 64 cells
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= ST_IDLE;
         wr_cnt  <= '0;
         o_done  <= 1'b0;
         o_valid <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_capture) begin
                  state   <= ST_ARMED;
                  o_valid <= 1'b0;
                  o_err   <= 1'b0;
               end
            end
            ST_ARMED: begin
               if (vs_fall && locked) begin
                  state  <= ST_CAP;
                  wr_cnt <= '0;
               end
            end
            ST_CAP: begin
               if (!locked) begin
                  state   <= ST_IDLE;
                  o_err   <= 1'b1;
                  o_valid <= 1'b0;
               end else if (cell_we) begin
                  wr_cnt <= wr_cnt + 6'd1;
                  if (wr_cnt == 6'd63) begin
                     state   <= ST_IDLE;
                     o_done  <= 1'b1;
                     o_valid <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Colour buffer write port; contents are only meaningful while o_valid
   always_ff @(posedge i_clk) begin
      if (cell_we)
         cell_mem[cell_addr] <= rgb;
   end

   // Registered read port; a colliding write shows up on the next read
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_rd_data <= '0;
      else
         o_rd_data <= cell_mem[i_rd_addr];
   end

   assign o_busy   = (state == ST_ARMED) || (state == ST_CAP);
   assign o_locked = locked;

endmodule

// File: tb/tb_vga_grid_capture.sv
// Bench for vga_grid_capture on a scaled-down raster so several frames fit
// in a short run. The stream source paints each grid cell as a solid block
// whose colour comes from exp_cell[], which is also the expected buffer.
module tb_vga_grid_capture;

   // Scaled timing: 56 clocks/line, 44 lines/frame, 4-pixel cells
   localparam int HT     = 56;
   localparam int VT     = 44;
   localparam int H_SYNC = 4;
   localparam int H_ACT  = 8;
   localparam int V_SYNC = 2;
   localparam int V_ACT  = 3;
   localparam int ACT_W  = 44;
   localparam int ACT_H  = 40;
   localparam int GX0    = 4;
   localparam int GY0    = 2;
   localparam int CL2    = 2;
   localparam int CELL   = 1 << CL2;
   localparam int GRID_W = 8 * CELL;
   localparam int WAIT_MAX = 6 * HT * VT;

   logic        clk;
   logic        rst_n;
   logic        capture;
   logic [5:0]  rd_addr;
   logic [11:0] rd_data;
   logic        busy, done, valid, locked, err;
   logic [9:0]  line_len, frame_lines;

   vga_grid_capture_if vid();

   vga_grid_capture #(
      .H_TOTAL     (HT),
      .V_TOTAL     (VT),
      .H_ACT_START (H_ACT),
      .V_ACT_START (V_ACT),
      .GRID_X0     (GX0),
      .GRID_Y0     (GY0),
      .CELL_LOG2   (CL2)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .vid           (vid),
      .i_capture     (capture),
      .i_rd_addr     (rd_addr),
      .o_rd_data     (rd_data),
      .o_busy        (busy),
      .o_done        (done),
      .o_valid       (valid),
      .o_locked      (locked),
      .o_err         (err),
      .o_line_len    (line_len),
      .o_frame_lines (frame_lines)
   );

   logic [11:0] exp_cell [64];
   int frame_no    = 0;
   int cur_ln      = 0;
   int cur_p       = 0;
   int short_frame = -1;
   int short_ln    = -1;
   int done_cnt    = 0;
   int done_frame  = -1;
   int n_chk       = 0;
   int n_err       = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Colour the source draws at active coordinate (x, y)
   function automatic logic [11:0] pix(input int x, input int y);
      if (x < 0 || x >= ACT_W || y < 0 || y >= ACT_H)
         return 12'h000;
      if (x >= GX0 && x < GX0 + GRID_W && y >= GY0 && y < GY0 + GRID_W)
         return exp_cell[((y - GY0) / CELL) * 8 + (x - GX0) / CELL];
      return 12'h3C3;
   endfunction

   // Free-running raster source; one line per frame may be shortened
   initial begin
      int len;
      vid.hsync = 1'b1;
      vid.vsync = 1'b1;
      {vid.r, vid.g, vid.b} = 12'h000;
      forever begin
         for (int ln = 0; ln < VT; ln++) begin
            len = (frame_no == short_frame && ln == short_ln) ? HT - 10 : HT;
            for (int p = 0; p < len; p++) begin
               @(negedge clk);
               cur_ln = ln;
               cur_p  = p;
               vid.hsync = (p >= H_SYNC);
               vid.vsync = (ln >= V_SYNC);
               {vid.r, vid.g, vid.b} = pix(p - H_ACT, ln - V_ACT);
            end
         end
         frame_no++;
      end
   end

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         done_frame = frame_no;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},   busy,        32'd0);
      chk({tag, "_done"},   done,        32'd0);
      chk({tag, "_valid"},  valid,       32'd0);
      chk({tag, "_locked"}, locked,      32'd0);
      chk({tag, "_err"},    err,         32'd0);
      chk({tag, "_len"},    line_len,    32'd0);
      chk({tag, "_lines"},  frame_lines, 32'd0);
      chk({tag, "_rd"},     rd_data,     32'd0);
   endtask

   // Wait (bounded) until the source is 20 pixels into line ln of frame f
   task automatic wait_pos(input int f, input int ln);
      int   n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < WAIT_MAX) begin
         @(posedge clk);
         n++;
         ok = (frame_no == f) && (cur_ln == ln) && (cur_p == 20);
      end
      @(negedge clk);
      chk($sformatf("reach_f%0d_l%0d", f, ln), ok, 32'd1);
   endtask

   task automatic pulse_capture();
      capture = 1'b1;
      @(negedge clk);
      capture = 1'b0;
   endtask

   task automatic read_all(input string tag);
      for (int a = 0; a < 64; a++) begin
         rd_addr = 6'(a);
         @(negedge clk);
         chk($sformatf("%s_rd%0d", tag, a), rd_data, exp_cell[a]);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      capture = 1'b0;
      rd_addr = '0;
      for (int k = 0; k < 64; k++)
         exp_cell[k] = {4'(k), 4'h5, 4'hA};

      // Reset state
      repeat (2) @(negedge clk);
      chk_all_zero("rst");
      rst_n = 1'b1;

      // Capture requested before lock waits for the first locked frame start
      wait_pos(0, 10);
      chk("prelock_locked", locked, 32'd0);
      pulse_capture();
      chk("prelock_busy", busy, 32'd1);
      wait_pos(1, 10);
      chk("lock_locked", locked, 32'd1);
      chk("lock_len", line_len, HT);
      chk("lock_lines", frame_lines, VT);
      chk("lock_busy", busy, 32'd1);
      chk("lock_nodone", done_cnt, 32'd0);
      wait_pos(3, 0);
      chk("cap1_done_cnt", done_cnt, 32'd1);
      chk("cap1_done_frame", done_frame, 32'd2);
      chk("cap1_valid", valid, 32'd1);
      chk("cap1_err", err, 32'd0);
      chk("cap1_busy", busy, 32'd0);
      read_all("cap1");

      // Random cell colours; a second request during capture is ignored
      for (int k = 0; k < 64; k++)
         exp_cell[k] = 12'($urandom);
      pulse_capture();
      chk("cap2_armed", busy, 32'd1);
      chk("cap2_valid_clr", valid, 32'd0);
      wait_pos(4, 10);
      pulse_capture();
      chk("cap2_busy", busy, 32'd1);
      wait_pos(5, 0);
      chk("cap2_done_cnt", done_cnt, 32'd2);
      chk("cap2_done_frame", done_frame, 32'd4);
      chk("cap2_valid", valid, 32'd1);
      chk("cap2_err", err, 32'd0);
      chk("cap2_busy", busy, 32'd0);
      read_all("cap2");

      // A short line in the middle of the captured frame aborts it
      short_frame = 6;
      short_ln    = 20;
      pulse_capture();
      wait_pos(6, 21);
      chk("abort_err", err, 32'd1);
      chk("abort_valid", valid, 32'd0);
      chk("abort_busy", busy, 32'd0);
      chk("abort_locked", locked, 32'd0);
      chk("abort_len", line_len, HT - 10);
      wait_pos(7, 10);
      chk("abort_nodone", done_cnt, 32'd2);
      chk("abort_err_sticky", err, 32'd1);
      chk("abort_relock", locked, 32'd1);

      // Reset in the middle of a capture, then a fresh capture
      pulse_capture();
      wait_pos(8, 15);
      chk("rst2_busy_before", busy, 32'd1);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_all_zero($sformatf("rst2_c%0d", i));
      end
      rst_n = 1'b1;
      for (int k = 0; k < 64; k++)
         exp_cell[k] = 12'($urandom);
      pulse_capture();
      wait_pos(9, 10);
      chk("cap3_wait_locked", locked, 32'd0);
      chk("cap3_wait_busy", busy, 32'd1);
      wait_pos(12, 0);
      chk("cap3_done_cnt", done_cnt, 32'd3);
      chk("cap3_done_frame", done_frame, 32'd11);
      chk("cap3_valid", valid, 32'd1);
      chk("cap3_err", err, 32'd0);
      read_all("cap3");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
